mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 49 ++++
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mau_byte_lane.sv | 61 ++++++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared opcodes, state encoding and defaults for mem_access_unit
// Purpose: common definitions for mem_access_unit, mau_byte_lane and the interface.
// Contents: opcode constants, FSM state enum, ENABLE/DISABLE, width defaults, op helpers.
package mem_access_unit_pkg;

    localparam int LEN_ADDR_DEF = 32;
    localparam int LEN_DATA_DEF = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h3;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } mau_state_e;

    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_valid = ENABLE;
            default:                                                  op_valid = DISABLE;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        op_is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                     (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Halfword ops must sit on an even address, word ops on a multiple of four.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: op_misaligned = off[0];
            OP_LW, OP_SW:         op_misaligned = (off != 2'b00);
            default:              op_misaligned = DISABLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline and RAM bus bundle for mem_access_unit
// Purpose: groups pipeline-side handshake and RAM-side bus signals.
// Modports: slave = the access unit; master = pipeline plus RAM environment.
interface mem_access_unit_if #(
    parameter int LEN_ADDR = 32,
    parameter int LEN_DATA = 32
);
    logic                req;
    logic [3:0]          op;
    logic [LEN_ADDR-1:0] vaddr;
    logic [LEN_DATA-1:0] wdata;
    logic                ready;
    logic                busy;
    logic                done;
    logic [LEN_DATA-1:0] rdata;
    logic                err;

    logic                ram_ce;
    logic                ram_we;
    logic [LEN_ADDR-1:0] ram_addr;
    logic [LEN_DATA-1:0] ram_wtData;
    logic [LEN_DATA-1:0] ram_rdData;

    modport slave (
        input  req, op, vaddr, wdata, ram_rdData,
        output ready, busy, done, rdata, err,
        output ram_ce, ram_we, ram_addr, ram_wtData
    );

    modport master (
        output req, op, vaddr, wdata, ram_rdData,
        input  ready, busy, done, rdata, err,
        input  ram_ce, ram_we, ram_addr, ram_wtData
    );
endinterface

// File: rtl/mau_byte_lane.sv
// rtl/mau_byte_lane.sv - big-endian lane extract/extend and store merge (combinational)
// Ports: op_i opcode, off_i byte offset, word_i RAM word, wdata_i store data (right-aligned),
//        load_o extended load result, merge_o word with addressed lane(s) replaced.
module mau_byte_lane
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Big-endian: offset 0 is the most significant byte.
    always_comb begin
        byte_v = word_i[31:24];
        case (off_i)
            2'd0: byte_v = word_i[31:24];
            2'd1: byte_v = word_i[23:16];
            2'd2: byte_v = word_i[15:8];
            2'd3: byte_v = word_i[7:0];
            default: byte_v = word_i[31:24];
        endcase
        half_v = off_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        load_o = word_i;
        case (op_i)
            OP_LB:   load_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_o = {24'h0, byte_v};
            OP_LH:   load_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_o = {16'h0, half_v};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (op_i)
            OP_SB: begin
                case (off_i)
                    2'd0: merge_o[31:24] = wdata_i[7:0];
                    2'd1: merge_o[23:16] = wdata_i[7:0];
                    2'd2: merge_o[15:8]  = wdata_i[7:0];
                    2'd3: merge_o[7:0]   = wdata_i[7:0];
                    default: merge_o = word_i;
                endcase
            end
            OP_SH: begin
                if (off_i[1]) merge_o[15:0]  = wdata_i[15:0];
                else          merge_o[31:16] = wdata_i[15:0];
            end
            OP_SW:   merge_o = wdata_i;
            default: merge_o = word_i;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit bridging the pipeline to a word-only big-endian RAM
// Ports: clk, rst (async active-high); bus (mem_access_unit_if.slave) carrying
//        req/op/vaddr/wdata/ready/busy/done/rdata/err and ram_ce/ram_we/ram_addr/ram_wtData/ram_rdData.
// Option: MEM_ALIGN_CHECK_EN - reject misaligned halfword/word accesses with err.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int LEN_ADDR = LEN_ADDR_DEF,
    parameter int LEN_DATA = LEN_DATA_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);
    mau_state_e          state_q;
    logic [3:0]          op_q;
    logic [1:0]          off_q;
    logic [LEN_DATA-1:0] wdata_q;
    logic                ram_ce_q;
    logic                ram_we_q;
    logic [LEN_ADDR-1:0] ram_addr_q;
    logic [LEN_DATA-1:0] ram_wtdata_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [LEN_DATA-1:0] rdata_q;

    logic [LEN_DATA-1:0] lane_load;
    logic [LEN_DATA-1:0] lane_merge;
    logic                misaligned;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = op_misaligned(bus.op, bus.vaddr[1:0]);
`else
    assign misaligned = DISABLE;
`endif

    mau_byte_lane u_lane (
        .op_i    (op_q),
        .off_i   (off_q),
        .word_i  (bus.ram_rdData),
        .wdata_i (wdata_q),
        .load_o  (lane_load),
        .merge_o (lane_merge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wtdata_q <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        op_q    <= bus.op;
                        off_q   <= bus.vaddr[1:0];
                        wdata_q <= bus.wdata;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (!op_valid(bus.op) || misaligned) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            ram_ce_q   <= 1'b1;
                            ram_addr_q <= {bus.vaddr[LEN_ADDR-1:2], 2'b00};
                            // A full word needs no read; sub-word stores read first.
                            if (bus.op == OP_SW) begin
                                state_q      <= ST_WRITE;
                                ram_we_q     <= 1'b1;
                                ram_wtdata_q <= bus.wdata;
                            end else begin
                                state_q <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (op_is_load(op_q)) begin
                        state_q    <= ST_DONE;
                        ram_ce_q   <= 1'b0;
                        ram_addr_q <= '0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b0;
                        rdata_q    <= lane_load;
                    end else begin
                        state_q      <= ST_WRITE;
                        ram_we_q     <= 1'b1;
                        ram_wtdata_q <= lane_merge;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_DONE;
                    ram_ce_q     <= 1'b0;
                    ram_we_q     <= 1'b0;
                    ram_addr_q   <= '0;
                    ram_wtdata_q <= '0;
                    done_q       <= 1'b1;
                    err_q        <= 1'b0;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ram_ce_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.ram_ce     = ram_ce_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wtData = ram_wtdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_access_unit_if #(.LEN_ADDR(32), .LEN_DATA(32)) bus ();

    mem_access_unit #(.LEN_ADDR(32), .LEN_DATA(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM model: combinational read, write committed at the rising edge.
    logic [31:0] mem [0:63];
    assign bus.ram_rdData = mem[bus.ram_addr[7:2]];
    always @(posedge clk) begin
        if (bus.ram_ce && bus.ram_we) mem[bus.ram_addr[7:2]] <= bus.ram_wtData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic e,
                         output int ce_n, output int we_n);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check("ready_wait", {31'h0, bus.ready}, 32'h1);
        bus.req   = 1'b1;
        bus.op    = op;
        bus.vaddr = addr;
        bus.wdata = wd;
        @(negedge clk);
        bus.req = 1'b0;
        lat  = 1;
        ce_n = 0;
        we_n = 0;
        n    = 0;
        while (n < 20) begin
            if (bus.ram_ce) ce_n++;
            if (bus.ram_we) we_n++;
            if (bus.done) break;
            @(negedge clk);
            lat++;
            n++;
        end
        if (!bus.done) check("done_timeout", {31'h0, bus.done}, 32'h1);
        rd = bus.rdata;
        e  = bus.err;
    endtask

    int          lat, ce_n, we_n;
    logic [31:0] rd;
    logic        e;
    logic        prev_done;
    int          done_cnt;

    initial begin
        checks    = 0;
        failures  = 0;
        bus.req   = 1'b0;
        bus.op    = 4'h0;
        bus.vaddr = '0;
        bus.wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        rst = 1'b1;
        #23;
        check("rst_ce",    {31'h0, bus.ram_ce}, 32'h0);
        check("rst_we",    {31'h0, bus.ram_we}, 32'h0);
        check("rst_addr",  bus.ram_addr, 32'h0);
        check("rst_wt",    bus.ram_wtData, 32'h0);
        check("rst_done",  {31'h0, bus.done}, 32'h0);
        check("rst_err",   {31'h0, bus.err}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_busy",  {31'h0, bus.busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'h0, bus.ready}, 32'h1);

        do_op(OP_SW, 32'h10, 32'h11223344, lat, rd, e, ce_n, we_n);
        check("sw_lat", lat, 2);
        check("sw_we_cycles", we_n, 1);
        check("sw_rdata_held", rd, 32'h0);
        do_op(OP_LW, 32'h10, 32'h0, lat, rd, e, ce_n, we_n);
        check("lw_data", rd, 32'h11223344);
        check("lw_lat", lat, 2);
        check("lw_err", {31'h0, e}, 32'h0);
        do_op(OP_LB, 32'h13, 32'h0, lat, rd, e, ce_n, we_n);
        check("lb13", rd, 32'h00000044);
        do_op(OP_LB, 32'h10, 32'h0, lat, rd, e, ce_n, we_n);
        check("lb10", rd, 32'h00000011);
        do_op(OP_SB, 32'h11, 32'h00000080, lat, rd, e, ce_n, we_n);
        check("sb_lat", lat, 3);
        check("sb_rdata_held", rd, 32'h00000011);
        do_op(OP_LB, 32'h11, 32'h0, lat, rd, e, ce_n, we_n);
        check("lb11_sext", rd, 32'hFFFFFF80);
        do_op(OP_LBU, 32'h11, 32'h0, lat, rd, e, ce_n, we_n);
        check("lbu11", rd, 32'h00000080);
        do_op(OP_LW, 32'h10, 32'h0, lat, rd, e, ce_n, we_n);
        check("sb_merged", rd, 32'h11803344);

        do_op(OP_SW, 32'h10, 32'h11223344, lat, rd, e, ce_n, we_n);
        do_op(OP_SH, 32'h12, 32'h0000BEEF, lat, rd, e, ce_n, we_n);
        check("sh_lat", lat, 3);
        check("sh_we_cycles", we_n, 1);
        check("sh_ce_cycles", ce_n, 2);
        do_op(OP_LW, 32'h10, 32'h0, lat, rd, e, ce_n, we_n);
        check("sh_merged", rd, 32'h1122BEEF);
        do_op(OP_LH, 32'h12, 32'h0, lat, rd, e, ce_n, we_n);
        check("lh12_sext", rd, 32'hFFFFBEEF);
        do_op(OP_LHU, 32'h10, 32'h0, lat, rd, e, ce_n, we_n);
        check("lhu10", rd, 32'h00001122);

        do_op(4'h2, 32'h10, 32'h0, lat, rd, e, ce_n, we_n);
        check("undef_err", {31'h0, e}, 32'h1);
        check("undef_lat", lat, 1);
        check("undef_ce", ce_n, 0);
        check("undef_rdata", rd, 32'h00001122);

        do_op(OP_LW, 32'h11, 32'h0, lat, rd, e, ce_n, we_n);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_err", {31'h0, e}, 32'h1);
        check("mis_ce", ce_n, 0);
        check("mis_rdata", rd, 32'h00001122);
`else
        check("mis_err", {31'h0, e}, 32'h0);
        check("mis_rdata", rd, 32'h1122BEEF);
`endif

        // Reset during the WRITE of a store must abort it.
        do_op(OP_SW, 32'h20, 32'hCAFEF00D, lat, rd, e, ce_n, we_n);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.op    = OP_SW;
        bus.vaddr = 32'h20;
        bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.req = 1'b0;
        check("in_write_we", {31'h0, bus.ram_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_ce",   {31'h0, bus.ram_ce}, 32'h0);
        check("abort_we",   {31'h0, bus.ram_we}, 32'h0);
        check("abort_addr", bus.ram_addr, 32'h0);
        check("abort_wt",   bus.ram_wtData, 32'h0);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_op(OP_LW, 32'h20, 32'h0, lat, rd, e, ce_n, we_n);
        check("abort_prior", rd, 32'hCAFEF00D);

        // req held high: re-accept only on the cycle after each done.
        @(negedge clk);
        bus.req   = 1'b1;
        bus.op    = OP_LW;
        bus.vaddr = 32'h10;
        prev_done = 1'b1;
        done_cnt  = 0;
        for (int c = 0; c < 9; c++) begin
            check("hold_ready_vs_busy", {31'h0, bus.ready}, {31'h0, ~bus.busy});
            check("hold_ready_after_done", {31'h0, bus.ready}, {31'h0, prev_done});
            if (bus.done) done_cnt++;
            prev_done = bus.done;
            @(negedge clk);
        end
        bus.req = 1'b0;
        check("hold_done_count", done_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
